// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, reset vector and the
// {inst, pc} entry carried through the fetch queue.
package cpu_pkg;

    localparam int AddrWidth = 32;
    localparam int InstWidth = 32;

    localparam logic [AddrWidth-1:0] ResetVec = '0;

    typedef struct packed {
        logic [InstWidth-1:0] inst;
        logic [AddrWidth-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// DEPTH-entry synchronous FIFO holding fetched {inst, pc} entries.
// Clear empties the queue in one cycle and wins over push/pop.
module fetch_inst_queue
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset_ || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset_ && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, one request per cycle
// to a blocking 1-cycle I-cache, queued delivery to the decoder, backend redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR      = AddrWidth,
    parameter int              INST      = InstWidth,
    parameter int              DEPTH     = 2,
    parameter logic [ADDR-1:0] RESET_VEC = ADDR'(ResetVec)
) (
    input  logic            clk,
    input  logic            reset_,
    output logic            ic_e,
    output logic [ADDR-1:0] ic_pc,
    input  logic [INST-1:0] ic_inst,
    input  logic            ic_miss,
    output logic            dec_valid,
    output logic [INST-1:0] dec_inst,
    output logic [ADDR-1:0] dec_pc,
    input  logic            dec_stall,
    input  logic            flush,
    input  logic [ADDR-1:0] flush_target
);

    localparam int              CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR-1:0] PC_STEP   = ADDR'(INST / 8);

    typedef struct packed {
        logic [INST-1:0] inst;
        logic [ADDR-1:0] pc;
    } entry_t;

    logic [ADDR-1:0]  pc;
    logic [ADDR-1:0]  req_pc;
    logic             inflight;

    logic             resp_hit;
    logic             resp_miss;
    logic             pop;
    logic [CNT_W:0]   occ_next;
    logic             credit;
    logic             issue;

    logic             q_push;
    entry_t           q_push_data;
    entry_t           q_head;
    logic [CNT_W-1:0] q_count;

    assign resp_hit  = inflight && !ic_miss;
    assign resp_miss = inflight && ic_miss;

    assign dec_valid = (q_count != '0);
    assign pop       = dec_valid && !dec_stall;

    // Entries committed after this cycle: buffered ones plus the in-flight one
    // (which either lands in the queue now or stays outstanding on a miss).
    assign occ_next  = {1'b0, q_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign credit    = (occ_next < DEPTH_OCC);

    assign issue     = !reset_ && !flush && (resp_miss || credit);
    assign ic_e      = issue;
    assign ic_pc     = resp_miss ? req_pc : pc;

    assign q_push           = resp_hit && !flush;
    assign q_push_data.inst = ic_inst;
    assign q_push_data.pc   = req_pc;

    assign dec_inst  = dec_valid ? q_head.inst : '0;
    assign dec_pc    = dec_valid ? q_head.pc   : '0;

    always_ff @(posedge clk) begin
        if (reset_) begin
            pc       <= RESET_VEC;
            req_pc   <= RESET_VEC;
            inflight <= 1'b0;
        end else if (flush) begin
            pc       <= flush_target;
            inflight <= 1'b0;
        end else if (resp_miss) begin
            // Cache holds the missed request; it was re-presented this cycle.
            inflight <= 1'b1;
        end else if (issue) begin
            req_pc   <= pc;
            pc       <= pc + PC_STEP;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_inst_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset_    (reset_),
        .clear     (flush),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: emulated 1-cycle I-cache, randomized
// stall/miss/flush/reset traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RVEC  = 32'h0;

    logic        clk = 1'b0;
    logic        reset_;
    logic        ic_e;
    logic [31:0] ic_pc;
    logic [31:0] ic_inst;
    logic        ic_miss;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_stall;
    logic        flush;
    logic [31:0] flush_target;

    fetch_unit #(
        .ADDR      (32),
        .INST      (32),
        .DEPTH     (DEPTH),
        .RESET_VEC (RVEC)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .ic_e         (ic_e),
        .ic_pc        (ic_pc),
        .ic_inst      (ic_inst),
        .ic_miss      (ic_miss),
        .dec_valid    (dec_valid),
        .dec_inst     (dec_inst),
        .dec_pc       (dec_pc),
        .dec_stall    (dec_stall),
        .flush        (flush),
        .flush_target (flush_target)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: program-order stream of buffered instructions plus at
    // most one outstanding cache request.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req;
    logic [31:0] next_del;
    bit          m_infl;
    bit          model_ok;

    bit          last_e;
    logic [31:0] last_pc;
    int          miss_pct;
    int          miss_left;
    logic [31:0] miss_addr;
    bit          force_miss;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step(input bit rst, input bit stall, input bit fl, input logic [31:0] tgt);
        bit          miss;
        bit          rmiss;
        bit          exp_v;
        bit          exp_e;
        bit          pop;
        int          occ;
        logic [31:0] exp_pc;
        ent_t        e;

        @(negedge clk);
        miss = 1'b0;
        if (last_e) begin
            if (force_miss) begin
                miss = 1'b1;
            end else if (miss_left > 0 && last_pc == miss_addr) begin
                miss = 1'b1;
                miss_left--;
            end else if ($urandom_range(99) < miss_pct) begin
                miss = 1'b1;
            end
        end
        reset_       = rst;
        dec_stall    = stall;
        flush        = fl;
        flush_target = tgt;
        ic_miss      = miss;
        ic_inst      = last_e ? inst_of(last_pc) : $urandom();
        #1;

        rmiss  = m_infl && miss;
        exp_v  = (mq.size() != 0);
        pop    = exp_v && !stall;
        occ    = mq.size() + int'(m_infl) - int'(pop);
        exp_e  = !rst && !fl && (rmiss || occ < DEPTH);
        exp_pc = rmiss ? m_req : m_pc;

        if (model_ok) begin
            check_eq("ic_e", ic_e, exp_e);
            if (exp_e) check_eq("ic_pc", ic_pc, exp_pc);
            check_eq("dec_valid", dec_valid, exp_v);
            if (exp_v) begin
                check_eq("dec_pc", dec_pc, mq[0].pc);
                check_eq("dec_inst", dec_inst, mq[0].inst);
            end
            if (pop) begin
                check_eq("stream_order", dec_pc, next_del);
                next_del = next_del + 32'd4;
            end
        end else if (rst) begin
            check_eq("ic_e_in_reset", ic_e, 32'd0);
        end

        if (rst) begin
            mq.delete();
            m_infl   = 1'b0;
            m_pc     = RVEC;
            m_req    = RVEC;
            next_del = RVEC;
            model_ok = 1'b1;
        end else if (fl) begin
            mq.delete();
            m_infl   = 1'b0;
            m_pc     = tgt;
            next_del = tgt;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl && !miss) begin
                e.pc   = m_req;
                e.inst = inst_of(m_req);
                mq.push_back(e);
            end
            if (!rmiss) begin
                if (exp_e) begin
                    m_req  = m_pc;
                    m_pc   = m_pc + 32'd4;
                    m_infl = 1'b1;
                end else begin
                    m_infl = 1'b0;
                end
            end
        end

        last_e  = ic_e;
        last_pc = ic_pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] frozen;
        logic [31:0] tgt;
        int          r;
        bit          rst_r;
        bit          fl_r;
        bit          stall_r;

        reset_ = 1'b1; dec_stall = 1'b0; flush = 1'b0; flush_target = '0;
        ic_miss = 1'b0; ic_inst = '0;
        miss_pct = 0; miss_left = 0; miss_addr = 32'h8; force_miss = 1'b0;
        last_e = 1'b0; last_pc = '0; model_ok = 1'b0;
        m_pc = '0; m_req = '0; next_del = '0; m_infl = 1'b0;

        repeat (3) step(1, 0, 0, 0);

        // Startup with a 3-cycle miss on the request to 0x8.
        miss_left = 3;
        step(0, 0, 0, 0);
        check_eq("rst_dec_valid", dec_valid, 32'd0);
        check_eq("rst_dec_pc", dec_pc, 32'd0);
        check_eq("rst_dec_inst", dec_inst, 32'd0);
        check_eq("start_pc0", ic_pc, 32'h0);
        step(0, 0, 0, 0);
        check_eq("start_pc1", ic_pc, 32'h4);
        check_eq("start_valid1", dec_valid, 32'd0);
        step(0, 0, 0, 0);
        check_eq("start_pc2", ic_pc, 32'h8);
        check_eq("first_valid", dec_valid, 32'd1);
        check_eq("first_dec_pc", dec_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check_eq("miss_reissue", ic_pc, 32'h8);
        end
        step(0, 0, 0, 0);
        check_eq("after_miss_pc", ic_pc, 32'hC);
        step(0, 0, 0, 0);
        check_eq("miss_delivered", dec_pc, 32'h8);
        step(0, 0, 0, 0);
        check_eq("after_miss_dec", dec_pc, 32'hC);

        // Decoder stall for 5 cycles.
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        frozen = dec_pc;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            check_eq("stall_frozen", dec_pc, frozen);
        end
        check_eq("stall_ic_e_off", ic_e, 32'd0);
        repeat (4) step(0, 0, 0, 0);

        // Flush while the queue is full.
        repeat (3) step(0, 1, 0, 0);
        check_eq("full_before_flush", dec_valid, 32'd1);
        step(0, 1, 1, 32'h100);
        step(0, 0, 0, 0);
        check_eq("flush_dec_valid", dec_valid, 32'd0);
        check_eq("flush_ic_e", ic_e, 32'd1);
        check_eq("flush_ic_pc", ic_pc, 32'h100);
        repeat (2) step(0, 0, 0, 0);
        check_eq("flush_first_pc", dec_pc, 32'h100);

        // Flush coinciding with a hit response.
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h200);
        step(0, 0, 0, 0);
        check_eq("flush_hit_ic_pc", ic_pc, 32'h200);
        repeat (2) step(0, 0, 0, 0);
        check_eq("flush_hit_first_pc", dec_pc, 32'h200);

        // Flush during an outstanding miss.
        repeat (3) step(0, 0, 0, 0);
        force_miss = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h300);
        force_miss = 1'b0;
        step(0, 0, 0, 0);
        check_eq("flush_miss_ic_e", ic_e, 32'd1);
        check_eq("flush_miss_ic_pc", ic_pc, 32'h300);
        repeat (2) step(0, 0, 0, 0);
        check_eq("flush_miss_first_pc", dec_pc, 32'h300);

        // One-cycle reset mid-stream.
        repeat (4) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("mid_rst_dec_valid", dec_valid, 32'd0);
        check_eq("mid_rst_ic_pc", ic_pc, RVEC);
        repeat (2) step(0, 0, 0, 0);
        check_eq("mid_rst_first_pc", dec_pc, RVEC);

        // Randomized traffic, including redirects near the top of the address space.
        miss_pct = 20;
        for (int i = 0; i < 4000; i++) begin
            r       = int'($urandom_range(999));
            rst_r   = (r < 5);
            fl_r    = (r >= 5 && r < 35);
            stall_r = ($urandom_range(99) < 35);
            tgt     = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            step(rst_r, stall_r, fl_r, tgt);
        end
        miss_pct = 0;
        repeat (8) step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
